// File: rtl/ysyx_22040000_rf_wb_arbiter.sv
// ysyx_22040000_rf_wb_arbiter: round-robin RF writeback arbiter with per-register busy scoreboard.
// Optional macro RF_WB_BYPASS_EN forwards the pending RF write to the decode operands.
module ysyx_22040000_rf_wb_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int NREQ   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*AWIDTH-1:0] req_waddr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    input  logic                   iss_valid,
    input  logic [AWIDTH-1:0]      iss_rd,
    output logic                   iss_ready,
    input  logic [AWIDTH-1:0]      rd_addr1,
    input  logic [AWIDTH-1:0]      rd_addr2,
    output logic                   rd_busy1,
    output logic                   rd_busy2,
    input  logic [DWIDTH-1:0]      rf_rdata1,
    input  logic [DWIDTH-1:0]      rf_rdata2,
    output logic [DWIDTH-1:0]      rdata1,
    output logic [DWIDTH-1:0]      rdata2,
    output logic                   rf_wen,
    output logic [AWIDTH-1:0]      rf_waddr,
    output logic [DWIDTH-1:0]      rf_wdata
);
    localparam int NREG = 2 ** AWIDTH;
    localparam int LW   = $clog2(NREQ);

    logic [NREG-1:0]   busy, busy_nxt;
    logic [LW-1:0]     last, gidx, idx;
    logic              found, xfer, iss_fire;
    logic [AWIDTH-1:0] g_waddr;
    logic [DWIDTH-1:0] g_wdata;

    // Scan starts just after the last granted requester and wraps around.
    always_comb begin
        gidx  = last;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(last) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign xfer      = found & ~rst;
    assign req_ready = xfer ? (NREQ'(1) << gidx) : '0;
    assign g_waddr   = req_waddr[int'(gidx)*AWIDTH +: AWIDTH];
    assign g_wdata   = req_wdata[int'(gidx)*DWIDTH +: DWIDTH];
    assign iss_ready = ~rst & ~busy[iss_rd];
    assign iss_fire  = iss_valid & iss_ready;

    // A set and a clear never hit the same register: issue is blocked while it is busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
        if (iss_fire) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            last     <= LW'(NREQ - 1);
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            busy   <= busy_nxt;
            rf_wen <= xfer && (g_waddr != '0);
            if (xfer) begin
                last     <= gidx;
                rf_waddr <= g_waddr;
                rf_wdata <= g_wdata;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic fwd1, fwd2;
    assign fwd1     = rf_wen && (rf_waddr == rd_addr1) && (rd_addr1 != '0);
    assign fwd2     = rf_wen && (rf_waddr == rd_addr2) && (rd_addr2 != '0);
    assign rd_busy1 = busy[rd_addr1] & ~fwd1;
    assign rd_busy2 = busy[rd_addr2] & ~fwd2;
    assign rdata1   = fwd1 ? rf_wdata : rf_rdata1;
    assign rdata2   = fwd2 ? rf_wdata : rf_rdata2;
`else
    assign rd_busy1 = busy[rd_addr1];
    assign rd_busy2 = busy[rd_addr2];
    assign rdata1   = rf_rdata1;
    assign rdata2   = rf_rdata2;
`endif

endmodule
